// File: rtl/scroll_pkg.sv
// Shared encodings for the line scroll controller: game states and level sizing.
package scroll_pkg;
  localparam int STATE_W = 2;
  localparam int LEVEL_W = 4;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;
endpackage

// File: rtl/scroll_tick_div.sv
// Loadable down-counter with hold; zero_o flags the terminal count.
module scroll_tick_div #(
  parameter int W = 20
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         hold_i,
  output logic         zero_o
);
  logic [W-1:0] r_cnt;

  // Load wins over hold so a start from IDLE/OVER can arm the counter.
  always_ff @(posedge clk_i) begin
    if (reset_i)                    r_cnt <= '0;
    else if (load_i)                r_cnt <= load_val_i;
    else if (!hold_i && r_cnt != '0) r_cnt <= r_cnt - W'(1);
  end

  assign zero_o = (r_cnt == '0);
endmodule

// File: rtl/line_scroll_ctrl.sv
// Scroll sequencer: game FSM, step strobe, one-hot lane rotation, score and level.
// Define SCROLL_SPEEDUP_EN to build the level counter and level-dependent step period.
module line_scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int BASE_PERIOD = 1_000_000,
  parameter int PERIOD_STEP = 62_500,
  parameter int MIN_PERIOD  = 250_000,
  parameter int LEVEL_STEPS = 64,
  parameter int SCORE_W     = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               pause_i,
  input  logic               collide_i,
  output logic               step_o,
  output logic [LANES-1:0]   lane_en_o,
  output logic [LEVEL_W-1:0] level_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [STATE_W-1:0] state_o
);
  localparam int CNT_W = $clog2(BASE_PERIOD);
  localparam int PTR_W = $clog2(LANES);
  localparam int LS_W  = (LEVEL_STEPS > 1) ? $clog2(LEVEL_STEPS) : 1;

  // Illegal parameter sets fail elaboration here.
  if (LANES < 2 || BASE_PERIOD < 2 || MIN_PERIOD < 2 || MIN_PERIOD > BASE_PERIOD ||
      LEVEL_STEPS < 1) begin : g_bad_params
    line_scroll_ctrl_bad_parameters u_bad ();
  end

  function automatic logic [31:0] period_of(input logic [LEVEL_W-1:0] lvl);
    logic [31:0] red;
    red = 32'(lvl) * 32'(PERIOD_STEP);
    if (red >= 32'(BASE_PERIOD) - 32'(MIN_PERIOD)) return 32'(MIN_PERIOD);
    return 32'(BASE_PERIOD) - red;
  endfunction

  state_t             r_state, w_state_nxt;
  logic               w_clear, w_step, w_hold, w_zero;
  logic [31:0]        w_period;
  logic [CNT_W-1:0]   w_load_val;
  logic [PTR_W-1:0]   r_ptr;
  logic [SCORE_W-1:0] r_score;
  logic               r_step;
  logic [LANES-1:0]   r_lane;

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Priority inside RUN: collision, then pause, then the counter step.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE, ST_OVER: if (start_i) begin
        w_state_nxt = ST_RUN;
        w_clear     = 1'b1;
      end
      ST_RUN: begin
        if (collide_i)    w_state_nxt = ST_OVER;
        else if (pause_i) w_state_nxt = ST_PAUSE;
        else if (w_zero)  w_step      = 1'b1;
      end
      ST_PAUSE: begin
        if (collide_i)    w_state_nxt = ST_OVER;
        else if (pause_i) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_hold     = (r_state != ST_RUN) || pause_i || collide_i;
  assign w_load_val = w_clear ? CNT_W'(BASE_PERIOD - 1) : CNT_W'(w_period - 32'd1);

  scroll_tick_div #(.W(CNT_W)) u_div (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (w_clear | w_step),
    .load_val_i (w_load_val),
    .hold_i     (w_hold),
    .zero_o     (w_zero)
  );

`ifdef SCROLL_SPEEDUP_EN
  logic [LEVEL_W-1:0] r_level, w_level_nxt;
  logic [LS_W-1:0]    r_lsteps;
  logic               w_lvl_wrap;

  assign w_lvl_wrap  = (r_lsteps == LS_W'(LEVEL_STEPS - 1));
  assign w_level_nxt = (w_step && w_lvl_wrap && r_level != LEVEL_MAX) ? r_level + 4'd1 : r_level;
  // Reload in the level-up cycle already uses the new level's period.
  assign w_period    = period_of(w_level_nxt);
  assign level_o     = r_level;

  always_ff @(posedge clk_i) begin
    if (reset_i || w_clear) begin
      r_level  <= '0;
      r_lsteps <= '0;
    end else if (w_step) begin
      r_level  <= w_level_nxt;
      r_lsteps <= w_lvl_wrap ? '0 : r_lsteps + LS_W'(1);
    end
  end
`else
  assign w_period = period_of('0);
  assign level_o  = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_step  <= 1'b0;
      r_lane  <= '0;
      r_ptr   <= '0;
      r_score <= '0;
    end else begin
      r_step <= w_step;
      r_lane <= w_step ? (LANES'(1) << r_ptr) : '0;
      if (w_clear) begin
        r_ptr   <= '0;
        r_score <= '0;
      end else if (w_step) begin
        r_ptr   <= (r_ptr == PTR_W'(LANES - 1)) ? '0 : r_ptr + PTR_W'(1);
        r_score <= (r_score == '1) ? r_score : r_score + SCORE_W'(1);
      end
    end
  end

  assign step_o    = r_step;
  assign lane_en_o = r_lane;
  assign score_o   = r_score;
  assign state_o   = r_state;
endmodule
